pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline. It drives the PC `stall_i`, the IF/ID hold and flush, and the ID/EX and MEM/WB bubble insertion.
- Arbitrates three stall sources with fixed priority: data-memory wait (multi-cycle handshake), load-use hazard, and taken-branch flush.
- Sits beside the hazard path in the CPU top; replaces ad-hoc stall wiring.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_stall_ctrl_if.sv | 40 ++++
 rtl/load_use_detect.sv | 27 ++
 rtl/pipe_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int PERF_W    = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } state_e;

  typedef logic [PERF_W-1:0] perf_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stall/flush outputs between the CPU datapath and pipe_stall_ctrl.
interface pipe_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
);
  logic             start_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_stall_o;
  logic             ifid_stall_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             exmem_stall_o;
  logic             memwb_bubble_o;
  logic             err_o;
  perf_t            stall_cycles_o;
  perf_t            flush_count_o;

  // Datapath side: drives hazard information, consumes the stall controls.
  modport master (
    output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           exmem_stall_o, memwb_bubble_o, err_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, mem_req_i, mem_ack_i,
    output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           exmem_stall_o, memwb_bubble_o, err_o, stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare; register 0 never creates a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             lu_o
);

  logic [REG_W-1:0] rs_eq;
  logic [REG_W-1:0] rt_eq;

  genvar gi;
  generate
    for (gi = 0; gi < REG_W; gi++) begin : gen_bit
      assign rs_eq[gi] = ex_rt_i[gi] ~^ id_rs_i[gi];
      assign rt_eq[gi] = ex_rt_i[gi] ~^ id_rt_i[gi];
    end
  endgenerate

  assign lu_o = memread_i && (|ex_rt_i) && ((&rs_eq) || (&rt_eq));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: memory wait > load-use > taken branch, Mealy outputs.
// Optional perf counters enabled by defining PIPE_STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_stall_ctrl_if.slave bus
);

  localparam int                WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic lu;
  logic freeze;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall, memwb_bubble;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .memread_i (bus.idex_memread_i),
    .ex_rt_i   (bus.idex_rt_i),
    .id_rs_i   (bus.ifid_rs_i),
    .id_rt_i   (bus.ifid_rt_i),
    .lu_o      (lu)
  );

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    freeze       = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (rst_i) begin
      pc_stall = 1'b1;
    end else if (!bus.start_i) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.mem_req_i && !bus.mem_ack_i) begin
            freeze  = 1'b1;
            state_d = ST_MWAIT;
            wcnt_d  = WCNT_ONE;
          end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end else if (bus.branch_taken_i) begin
            ifid_flush = 1'b1;
          end
        end
        ST_MWAIT: begin
          // A dropped request without ack is abandoned quietly, not flagged.
          if (bus.mem_ack_i || !bus.mem_req_i) begin
            state_d = ST_RUN;
            wcnt_d  = '0;
          end else begin
            freeze = 1'b1;
            if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + WCNT_ONE;
          end
        end
        default: state_d = ST_RUN;
      endcase
      if (freeze) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
        if (wcnt_d == WCNT_MAX) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_stall_o     = pc_stall;
  assign bus.ifid_stall_o   = ifid_stall;
  assign bus.ifid_flush_o   = ifid_flush;
  assign bus.idex_bubble_o  = idex_bubble;
  assign bus.exmem_stall_o  = exmem_stall;
  assign bus.memwb_bubble_o = memwb_bubble;
  assign bus.err_o          = err_q && !rst_i && bus.start_i;

`ifdef PIPE_STALL_PERF_CNT_EN
  perf_t stall_cnt_q;
  perf_t flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && bus.start_i) stall_cnt_q <= stall_cnt_q + perf_t'(1);
      if (ifid_flush)              flush_cnt_q <= flush_cnt_q + perf_t'(1);
    end
  end

  assign bus.stall_cycles_o = (rst_i || !bus.start_i) ? '0 : stall_cnt_q;
  assign bus.flush_count_o  = (rst_i || !bus.start_i) ? '0 : flush_cnt_q;
`else
  assign bus.stall_cycles_o = '0;
  assign bus.flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MAX_WAIT=4 so the timeout is reachable.
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  // Output vector order: pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall, memwb_bubble, err
  localparam logic [6:0] O_RST   = 7'b1000000;
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1101000;
  localparam logic [6:0] O_FRZ   = 7'b1100110;
  localparam logic [6:0] O_FLUSH = 7'b0010000;
  localparam logic [6:0] O_STOP  = 7'b1100000;
  localparam logic [6:0] O_ERR   = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_stall_ctrl_if #(.REG_W(5)) bus ();

  pipe_stall_ctrl #(.REG_W(5), .MAX_WAIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {bus.pc_stall_o, bus.ifid_stall_o, bus.ifid_flush_o, bus.idex_bubble_o,
                 bus.exmem_stall_o, bus.memwb_bubble_o, bus.err_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic set_in(input logic st, input logic mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic br,
                        input logic rq, input logic ak);
    bus.start_i        = st;
    bus.idex_memread_i = mr;
    bus.idex_rt_i      = xrt;
    bus.ifid_rs_i      = rs;
    bus.ifid_rt_i      = rt;
    bus.branch_taken_i = br;
    bus.mem_req_i      = rq;
    bus.mem_ack_i      = ak;
  endtask

  // Check outputs mid-cycle, then step to just after the next rising edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #3;
    chk(tag, {25'd0, outs}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`ifdef PIPE_STALL_PERF_CNT_EN
    exp_stall = 32'd3;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif

    // Reset with hazards present: only pc_stall may show.
    rst = 1'b1;
    set_in(1, 1, 5'd8, 5'd8, 0, 1, 1, 0);
    cyc("reset_c0", O_RST);
    cyc("reset_c1", O_RST);
    rst = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_after_reset", O_IDLE);

    // Load-use beats branch; register 0 never stalls.
    set_in(1, 1, 5'd8, 5'd8, 5'd3, 1, 0, 0);
    cyc("lu_rs_over_branch", O_LU);
    set_in(1, 1, 5'd8, 5'd3, 5'd8, 0, 0, 0);
    cyc("lu_rt", O_LU);
    set_in(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    cyc("lu_r0_none", O_IDLE);
    set_in(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    cyc("r0_branch_flush", O_FLUSH);
    set_in(1, 0, 5'd8, 5'd8, 5'd8, 0, 0, 0);
    cyc("no_load_no_stall", O_IDLE);

    // One-cycle hit stays in RUN (next cycle load-use is honoured).
    set_in(1, 0, 0, 0, 0, 0, 1, 1);
    cyc("mem_hit", O_IDLE);
    set_in(1, 1, 5'd9, 5'd9, 0, 0, 0, 0);
    cyc("after_hit_lu", O_LU);

    // Memory wait of 3 cycles with hazards pending; ack cycle all low.
    set_in(1, 1, 5'd9, 5'd9, 0, 1, 1, 0);
    cyc("mwait_w1", O_FRZ);
    cyc("mwait_w2", O_FRZ);
    cyc("mwait_w3", O_FRZ);
    set_in(1, 1, 5'd9, 5'd9, 0, 1, 1, 1);
    cyc("mwait_ack", O_IDLE);
    set_in(1, 1, 5'd9, 5'd9, 0, 1, 0, 0);
    cyc("after_ack_lu", O_LU);
    set_in(1, 0, 0, 0, 0, 1, 0, 0);
    cyc("after_ack_flush", O_FLUSH);

    // start_i low mid-wait holds the state.
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    cyc("pause_enter_wait", O_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("pause_stop", O_STOP);
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    cyc("pause_resume_wait", O_FRZ);
    set_in(1, 0, 0, 0, 0, 0, 1, 1);
    cyc("pause_ack", O_IDLE);

    // Timeout: err rises after the 4th wait cycle and is sticky past ack.
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    cyc("to_w1", O_FRZ);
    cyc("to_w2", O_FRZ);
    cyc("to_w3", O_FRZ);
    cyc("to_w4_noerr", O_FRZ);
    cyc("to_w5_err", O_FRZ | O_ERR);
    cyc("to_w6_err", O_FRZ | O_ERR);
    set_in(1, 0, 0, 0, 0, 0, 1, 1);
    cyc("to_ack_err", O_ERR);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    cyc("to_idle_err", O_ERR);
    set_in(1, 1, 5'd4, 5'd4, 0, 0, 0, 0);
    cyc("to_lu_err", O_LU | O_ERR);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("to_stop", O_STOP);
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    cyc("to_reset", O_RST);
    rst = 1'b0;
    cyc("to_err_cleared", O_IDLE);

    // Perf: 3 load-use stalls, 2 flushes, 5 paused cycles.
    set_in(1, 1, 5'd7, 5'd7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("perf_lu", O_LU);
    set_in(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("perf_flush", O_FLUSH);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("perf_stop", O_STOP);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("perf_stall_cycles", bus.stall_cycles_o, exp_stall);
    chk("perf_flush_count", bus.flush_count_o, exp_flush);
    chk("perf_idle", {25'd0, outs}, {25'd0, O_IDLE});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
